// File: rtl/led_chaser_ctrl_if.sv
// Button/strobe bundle between the board keys, the chaser control stage and
// the downstream LED chaser.
//   key_speed_n, key_dir_n, key_pause_n : raw active-low buttons
//   step      : one-clock shift strobe
//   dir       : 0 = rotate toward MSB, 1 = rotate toward LSB
//   paused    : step generation halted
//   speed_sel : 0 slowest .. 3 fastest
// master = side that drives the keys and observes the controls (board/bench).
// slave  = the control stage itself.
interface led_chaser_ctrl_if;
  logic       key_speed_n;
  logic       key_dir_n;
  logic       key_pause_n;
  logic       step;
  logic       dir;
  logic       paused;
  logic [1:0] speed_sel;

  modport master (
    output key_speed_n, key_dir_n, key_pause_n,
    input  step, dir, paused, speed_sel
  );

  modport slave (
    input  key_speed_n, key_dir_n, key_pause_n,
    output step, dir, paused, speed_sel
  );
endinterface

// File: rtl/led_chaser_ctrl.sv
// LED chaser control stage: synchronises and debounces three raw buttons,
// turns key presses into speed / direction / pause state, and produces the
// registered single-cycle step strobe that advances the chaser.
//   clk   : 12 MHz board clock
//   rst_n : asynchronous active-low reset
//   bus   : led_chaser_ctrl_if.slave (keys in, step/dir/paused/speed_sel out)

// Per-key lane: 2-flop synchroniser, stability-count debounce, press pulse.
module led_chaser_key_db #(
  parameter int DEBOUNCE_CYC = 240000,
  parameter int CNT_W        = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);
  logic [1:0]       sync_q;
  logic             lvl_q, lvl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             synced;

  assign synced = sync_q[1];

  // Counter only runs while the synced level disagrees with the accepted
  // level; any agreement restarts the stability window.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    press = 1'b0;
    if (synced != lvl_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
        lvl_d = synced;
        press = ~synced;  // only the 1->0 transition is an event
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      lvl_q  <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], key_n};
      lvl_q  <= lvl_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

module led_chaser_ctrl #(
  parameter int DEBOUNCE_CYC = 240000,
  parameter int BASE_DIV     = 1200000,
  parameter int CNT_W        = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  led_chaser_ctrl_if.slave   bus
);
  localparam int NUM_KEYS  = 3;
  localparam int KEY_SPD   = 0;
  localparam int KEY_DIR   = 1;
  localparam int KEY_PAUSE = 2;

  logic [NUM_KEYS-1:0] key_n, press;

  assign key_n = {bus.key_pause_n, bus.key_dir_n, bus.key_speed_n};

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    led_chaser_key_db #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .CNT_W       (CNT_W)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .key_n(key_n[k]),
      .press(press[k])
    );
  end

  logic [CNT_W-1:0] cnt_q, cnt_d, period_m1;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             paused_q, paused_d;
  logic [1:0]       spd_q, spd_d;

  // Period is BASE_DIV scaled by 8/4/2/1 for speed 0..3.
  assign period_m1 = (CNT_W'(BASE_DIV) << (2'd3 - spd_q)) - CNT_W'(1);

  always_comb begin
    cnt_d    = cnt_q;
    step_d   = 1'b0;
    dir_d    = dir_q ^ press[KEY_DIR];
    paused_d = paused_q ^ press[KEY_PAUSE];
    spd_d    = spd_q;
    if (press[KEY_SPD]) begin
      // Speed change restarts the period and suppresses this cycle's step.
      spd_d = spd_q + 2'd1;
      cnt_d = '0;
    end else if (!paused_q) begin
      // >= rather than == so a shorter new period cannot strand the count.
      if (cnt_q >= period_m1) begin
        cnt_d  = '0;
        step_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      paused_q <= 1'b0;
      spd_q    <= 2'd1;
    end else begin
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      paused_q <= paused_d;
      spd_q    <= spd_d;
    end
  end

  assign bus.step      = step_q;
  assign bus.dir       = dir_q;
  assign bus.paused    = paused_q;
  assign bus.speed_sel = spd_q;
endmodule

// File: tb/tb_led_chaser_ctrl.sv
// Bench for led_chaser_ctrl with short debounce/period values. Key presses
// push their expected acceptance edge onto a scoreboard queue; a per-edge
// reference of the control behaviour pops them when due and every edge the
// DUT outputs are compared against it, plus targeted timing checks.
module tb_led_chaser_ctrl;
  localparam int DEB  = 4;
  localparam int BDIV = 10;
  localparam int CW   = 24;
  localparam int ACC  = 6;  // 2 sync edges + DEB debounce edges

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  led_chaser_ctrl_if bus();

  led_chaser_ctrl #(.DEBOUNCE_CYC(DEB), .BASE_DIV(BDIV), .CNT_W(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int key; } ev_t;
  ev_t evq[$];

  int n_chk  = 0;
  int n_fail = 0;
  int e      = 0;

  logic [1:0] m_spd;
  int         m_cnt;
  logic       m_step, m_dir, m_paused;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
    end
  endtask

  function automatic void m_reset();
    m_spd    = 2'd1;
    m_cnt    = 0;
    m_step   = 1'b0;
    m_dir    = 1'b0;
    m_paused = 1'b0;
  endfunction

  function automatic int m_period();
    return BDIV << (3 - int'(m_spd));
  endfunction

  // Reference behaviour for one clock edge.
  function automatic void m_advance();
    bit sp = 0, dr = 0, pa = 0;
    int p;
    while (evq.size() > 0 && evq[0].due <= e) begin
      case (evq[0].key)
        0:       sp = 1;
        1:       dr = 1;
        default: pa = 1;
      endcase
      void'(evq.pop_front());
    end
    p = m_period();
    if (sp) begin
      m_spd  = m_spd + 2'd1;
      m_cnt  = 0;
      m_step = 1'b0;
    end else if (m_paused) begin
      m_step = 1'b0;
    end else if (m_cnt >= p - 1) begin
      m_cnt  = 0;
      m_step = 1'b1;
    end else begin
      m_cnt  = m_cnt + 1;
      m_step = 1'b0;
    end
    if (dr) m_dir = ~m_dir;
    if (pa) m_paused = ~m_paused;
  endfunction

  initial m_reset();

  always @(posedge clk) begin
    #1;
    e++;
    if (!rst_n) m_reset();
    else        m_advance();
    chk("outs", {27'd0, bus.step, bus.dir, bus.paused, bus.speed_sel},
                {27'd0, m_step, m_dir, m_paused, m_spd});
  end

  // keys bitmask: bit0 speed, bit1 dir, bit2 pause
  task automatic drive(input int keys, input logic v);
    if (keys[0]) bus.key_speed_n = v;
    if (keys[1]) bus.key_dir_n   = v;
    if (keys[2]) bus.key_pause_n = v;
  endtask

  task automatic press(input int keys, input int hold);
    @(negedge clk);
    drive(keys, 1'b0);
    if (hold >= DEB)
      for (int k = 0; k < 3; k++)
        if (keys[k]) evq.push_back('{e + ACC, k});
    repeat (hold) @(negedge clk);
    drive(keys, 1'b1);
    repeat (12) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int p;
    bus.key_speed_n = 1'b1;
    bus.key_dir_n   = 1'b1;
    bus.key_pause_n = 1'b1;
    idle(3);
    chk("rst_vals", {28'd0, bus.step, bus.dir, bus.paused, bus.speed_sel},
                    {28'd0, 1'b0, 1'b0, 1'b0, 2'd1});
    rst_n = 1'b1;

    // first step 40 edges after reset release at speed 1
    first = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (bus.step) begin first = i; break; end
    end
    chk("first_step", first, 40);
    @(negedge clk);
    idle(45);

    // 3-cycle glitch rejected, 10-cycle hold accepted once
    press(1, 3);
    chk("glitch_spd", bus.speed_sel, 2'd1);
    press(1, 10);
    chk("spd_to_2", bus.speed_sel, 2'd2);
    idle(30);

    // speed wraps 3,0,1,2
    for (int i = 0; i < 4; i++) begin
      logic [1:0] exp_s;
      exp_s = 2'(3 + i);
      press(1, 5);
      idle(100);
      chk("spd_seq", bus.speed_sel, exp_s);
    end

    // pause mid-period, hold, resume
    for (int i = 0; i < 100 && m_cnt != 9; i++) @(negedge clk);
    if (m_cnt != 9) chk("wait_pause", 0, 1);
    press(4, 5);
    idle(200);
    chk("paused_on", bus.paused, 1'b1);
    press(4, 5);
    idle(60);
    chk("paused_off", bus.paused, 1'b0);

    // speed + pause accepted on the same edge
    press(5, 6);
    chk("sp_pa_spd", bus.speed_sel, 2'd3);
    chk("sp_pa_pau", bus.paused, 1'b1);
    press(4, 5);
    idle(50);

    // dir accepted exactly on the terminal-count edge
    p = m_period();
    for (int i = 0; i < 200 && m_cnt != p - ACC; i++) @(negedge clk);
    if (m_cnt != p - ACC) chk("wait_dir", 0, 1);
    drive(2, 1'b0);
    evq.push_back('{e + ACC, 1});
    repeat (ACC) @(posedge clk);
    #1;
    chk("dir_tc_step", bus.step, 1'b1);
    chk("dir_tc_dir", bus.dir, 1'b1);
    @(negedge clk);
    drive(2, 1'b1);
    idle(12);
    press(2, 5);
    idle(40);
    chk("dir_back", bus.dir, 1'b0);

    // async reset mid-period while a key is mid-debounce; key held through
    press(1, 5);
    idle(7);
    @(negedge clk);
    drive(2, 1'b0);
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vals", {28'd0, bus.step, bus.dir, bus.paused, bus.speed_sel},
                     {28'd0, 1'b0, 1'b0, 1'b0, 2'd1});
    evq.delete();
    idle(2);
    rst_n = 1'b1;
    evq.push_back('{e + ACC, 1});
    idle(10);
    drive(2, 1'b1);
    idle(20);
    chk("held_dir", bus.dir, 1'b1);
    idle(5);
    chk("evq_drained", evq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
